// File: rtl/serial_divisibility_by_n_using_fsm_pkg.sv
// Shared types and modular-arithmetic helper for the serial divisibility tester.
// All arithmetic fits in 9 bits because the divisor never exceeds 255.
package serial_div_pkg;

  localparam int SUM_W = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MSB  = 2'd1,
    LSB  = 2'd2
  } sdiv_state_t;

  // (a+b) mod n with a single conditional subtract; valid while a+b < 2n.
  function automatic logic [SUM_W-1:0] mod_add_sub(input logic [SUM_W-1:0] a,
                                                   input logic [SUM_W-1:0] b,
                                                   input logic [SUM_W-1:0] n);
    logic [SUM_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, n}) begin
      s = s - {1'b0, n};
    end else begin
      s = s;
    end
    return s[SUM_W-1:0];
  endfunction

endpackage

// File: rtl/serial_divisibility_by_n_using_fsm_reduce.sv
// Combinational modular adder: one conditional subtract of DIVISOR.
// Callers guarantee i_a + i_b < 2*DIVISOR.
module mod_n_reduce
  import serial_div_pkg::*;
#(
  parameter int DIVISOR = 5,
  parameter int IN_W    = 4,
  parameter int OUT_W   = 3
) (
  input  logic [IN_W-1:0]  i_a,
  input  logic [IN_W-1:0]  i_b,
  output logic [OUT_W-1:0] o_sum
);

  assign o_sum = OUT_W'(mod_add_sub(SUM_W'(i_a), SUM_W'(i_b), SUM_W'(DIVISOR)));

endmodule

// File: rtl/serial_divisibility_by_n_using_fsm.sv
// Serial "X mod DIVISOR" tracker: one bit per accepted beat, MSB- or LSB-first per number.
// Remainder, divisibility flag and bit count are registered with one cycle of latency.
module serial_divisibility_by_n_using_fsm
  import serial_div_pkg::*;
#(
  parameter int DIVISOR = 5,
  parameter int CNT_W   = 16,
  localparam int REM_W  = $clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             start,
  input  logic             lsb_first,
  output logic             out_valid,
  output logic [REM_W-1:0] rem,
  output logic             div_by_n,
  output logic [CNT_W-1:0] bit_count
);

  localparam int AW = REM_W + 1;
  localparam logic [REM_W-1:0] ONE_MOD = REM_W'(1 % DIVISOR);

  sdiv_state_t      r_state;
  sdiv_state_t      w_state_nxt;
  logic [REM_W-1:0] r_rem;
  logic [REM_W-1:0] r_weight;
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;

  logic             w_first;
  logic             w_lsb;
  logic [REM_W-1:0] w_rem_base;
  logic [REM_W-1:0] w_wt_base;
  logic [AW-1:0]    w_rem_a;
  logic [AW-1:0]    w_rem_b;
  logic [AW-1:0]    w_wt_dbl;
  logic [REM_W-1:0] w_rem_nxt;
  logic [REM_W-1:0] w_wt_nxt;

  // Next-state and operand selection; a first bit starts from r=0, w=1%N.
  always_comb begin
    w_first     = 1'b0;
    w_lsb       = 1'b0;
    w_rem_base  = r_rem;
    w_wt_base   = r_weight;
    w_rem_a     = '0;
    w_rem_b     = '0;
    w_state_nxt = r_state;

    if (in_valid) begin
      w_first = start || (r_state == IDLE);
    end else begin
      w_first = 1'b0;
    end

    if (w_first) begin
      w_rem_base  = '0;
      w_wt_base   = ONE_MOD;
      w_lsb       = lsb_first;
      w_state_nxt = lsb_first ? LSB : MSB;
    end else begin
      case (r_state)
        LSB:     w_lsb = 1'b1;
        default: w_lsb = 1'b0;
      endcase
    end

    // MSB step is 2r+b, LSB step is r + b*w; both stay below 2N.
    if (w_lsb) begin
      w_rem_a = AW'(w_rem_base);
      w_rem_b = in_bit ? AW'(w_wt_base) : '0;
    end else begin
      w_rem_a = {w_rem_base, in_bit};
      w_rem_b = '0;
    end
  end

  assign w_wt_dbl = AW'(w_wt_base);

  mod_n_reduce #(
    .DIVISOR (DIVISOR),
    .IN_W    (AW),
    .OUT_W   (REM_W)
  ) u_rem_reduce (
    .i_a   (w_rem_a),
    .i_b   (w_rem_b),
    .o_sum (w_rem_nxt)
  );

  mod_n_reduce #(
    .DIVISOR (DIVISOR),
    .IN_W    (AW),
    .OUT_W   (REM_W)
  ) u_wt_reduce (
    .i_a   (w_wt_dbl),
    .i_b   (w_wt_dbl),
    .o_sum (w_wt_nxt)
  );

  // State, remainder, weight and saturating count; everything holds on bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_weight    <= ONE_MOD;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_state  <= w_state_nxt;
        r_rem    <= w_rem_nxt;
        r_weight <= w_wt_nxt;
        if (w_first) begin
          r_count <= CNT_W'(1);
        end else if (r_count != '1) begin
          r_count <= r_count + CNT_W'(1);
        end else begin
          r_count <= r_count;
        end
      end else begin
        r_state  <= r_state;
        r_rem    <= r_rem;
        r_weight <= r_weight;
        r_count  <= r_count;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign rem       = r_rem;
  assign div_by_n  = (r_rem == '0);
  assign bit_count = r_count;

endmodule

// File: tb/tb_serial_divisibility_by_n_using_fsm.sv
// Directed bench: four instances (N=5,7 with 16-bit counters; N=2,8 with 4-bit counters)
// share one stimulus stream and are compared against hand-computed and modelled values.
module tb_serial_divisibility_by_n_using_fsm;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_bit;
  logic start;
  logic lsb_first;

  logic        ov5, ov7, ov2, ov8;
  logic [2:0]  rem5, rem7, rem8;
  logic [0:0]  rem2;
  logic        dv5, dv7, dv2, dv8;
  logic [15:0] cnt5, cnt7;
  logic [3:0]  cnt2, cnt8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_divisibility_by_n_using_fsm #(.DIVISOR(5), .CNT_W(16)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .start(start),
    .lsb_first(lsb_first), .out_valid(ov5), .rem(rem5), .div_by_n(dv5), .bit_count(cnt5));

  serial_divisibility_by_n_using_fsm #(.DIVISOR(7), .CNT_W(16)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .start(start),
    .lsb_first(lsb_first), .out_valid(ov7), .rem(rem7), .div_by_n(dv7), .bit_count(cnt7));

  serial_divisibility_by_n_using_fsm #(.DIVISOR(2), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .start(start),
    .lsb_first(lsb_first), .out_valid(ov2), .rem(rem2), .div_by_n(dv2), .bit_count(cnt2));

  serial_divisibility_by_n_using_fsm #(.DIVISOR(8), .CNT_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .start(start),
    .lsb_first(lsb_first), .out_valid(ov8), .rem(rem8), .div_by_n(dv8), .bit_count(cnt8));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One accepted beat; outputs are sampled 1 time unit after the accepting edge.
  task automatic send(input logic b, input logic st, input logic lsb);
    in_valid  = 1'b1;
    in_bit    = b;
    start     = st;
    lsb_first = lsb;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    start     = 1'b0;
  endtask

  task automatic bubble(input logic st);
    in_valid = 1'b0;
    start    = st;
    in_bit   = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
  endtask

  task automatic check5(input string tag, input int r, input int c);
    check_eq({tag, " rem"}, 32'(rem5), 32'(r));
    check_eq({tag, " div"}, 32'(dv5), (r == 0) ? 32'd1 : 32'd0);
    check_eq({tag, " cnt"}, 32'(cnt5), 32'(c));
    check_eq({tag, " ov"}, 32'(ov5), 32'd1);
  endtask

  // 40-bit number fed LSB-first; every prefix is checked for N=2 and N=8.
  task automatic run_lsb40(input logic [39:0] v);
    logic [63:0] pre;
    pre = 64'd0;
    for (int k = 0; k < 40; k++) begin
      send(v[k], (k == 0) ? 1'b1 : 1'b0, 1'b1);
      pre[k] = v[k];
      check_eq($sformatf("lsb40 n2 bit%0d", k), 32'(rem2), 32'(pre % 64'd2));
      check_eq($sformatf("lsb40 n8 bit%0d", k), 32'(rem8), 32'(pre % 64'd8));
    end
    check_eq("lsb40 n5 rem", 32'(rem5), 32'({24'd0, v} % 64'd5));
    check_eq("lsb40 n7 rem", 32'(rem7), 32'({24'd0, v} % 64'd7));
    check_eq("lsb40 n8 div", 32'(dv8), (v[2:0] == 3'd0) ? 32'd1 : 32'd0);
    check_eq("lsb40 n2 sat", 32'(cnt2), 32'd15);
    check_eq("lsb40 n8 sat", 32'(cnt8), 32'd15);
    check_eq("lsb40 n5 cnt", 32'(cnt5), 32'd40);
  endtask

  // 40-bit number fed MSB-first; every prefix is checked for N=5 and N=7.
  task automatic run_msb40(input logic [39:0] v);
    logic [63:0] pre;
    pre = 64'd0;
    for (int k = 39; k >= 0; k--) begin
      send(v[k], (k == 39) ? 1'b1 : 1'b0, 1'b0);
      pre = {pre[62:0], v[k]};
      check_eq($sformatf("msb40 n5 bit%0d", k), 32'(rem5), 32'(pre % 64'd5));
      check_eq($sformatf("msb40 n7 bit%0d", k), 32'(rem7), 32'(pre % 64'd7));
    end
    check_eq("msb40 n2 rem", 32'(rem2), 32'(v[0]));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    start     = 1'b0;
    lsb_first = 1'b0;
    @(posedge clk);
    #1;
    check_eq("reset rem", 32'(rem5), 32'd0);
    check_eq("reset div", 32'(dv5), 32'd1);
    check_eq("reset cnt", 32'(cnt5), 32'd0);
    check_eq("reset ov", 32'(ov5), 32'd0);
    rst_n = 1'b1;
    bubble(1'b0);

    // MSB-first 1010 back to back: 1,2,5->0,10->0
    send(1'b1, 1'b1, 1'b0); check5("t1 b0", 1, 1);
    send(1'b0, 1'b0, 1'b0); check5("t1 b1", 2, 2);
    send(1'b1, 1'b0, 1'b0); check5("t1 b2", 0, 3);
    send(1'b0, 1'b0, 1'b0); check5("t1 b3", 0, 4);
    check_eq("t1 n7 rem", 32'(rem7), 32'd3);
    bubble(1'b0);
    check_eq("t1 ov drop", 32'(ov5), 32'd0);

    // LSB-first 1,0,1 = 5, then restart LSB 0,0,0,1 = 8
    send(1'b1, 1'b1, 1'b1); check5("t2 b0", 1, 1);
    send(1'b0, 1'b0, 1'b0); check5("t2 b1", 1, 2);
    send(1'b1, 1'b0, 1'b0); check5("t2 b2", 0, 3);
    send(1'b0, 1'b1, 1'b1); check5("t2 c0", 0, 1);
    send(1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0); check5("t2 c3", 3, 4);

    // N=7 MSB 111 with gaps; a start without in_valid is ignored
    send(1'b1, 1'b1, 1'b0);
    check_eq("t3 b0 rem", 32'(rem7), 32'd1);
    bubble(1'b1);
    check_eq("t3 gap ov", 32'(ov7), 32'd0);
    check_eq("t3 gap rem", 32'(rem7), 32'd1);
    check_eq("t3 gap cnt", 32'(cnt7), 32'd1);
    send(1'b1, 1'b0, 1'b0);
    check_eq("t3 b1 rem", 32'(rem7), 32'd3);
    check_eq("t3 b1 ov", 32'(ov7), 32'd1);
    bubble(1'b0);
    bubble(1'b0);
    check_eq("t3 gap2 rem", 32'(rem7), 32'd3);
    send(1'b1, 1'b0, 1'b0);
    check_eq("t3 b2 rem", 32'(rem7), 32'd0);
    check_eq("t3 b2 div", 32'(dv7), 32'd1);
    check_eq("t3 b2 cnt", 32'(cnt7), 32'd3);

    // Mid-number restart as LSB-first; 1,1,0 LSB = 3 (MSB order would give 1)
    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0); check5("t4 pre", 3, 2);
    send(1'b1, 1'b1, 1'b1); check5("t4 restart", 1, 1);
    send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0); check5("t4 lsb order", 3, 3);

    // Reset mid-number, even with a valid beat present
    send(1'b1, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b0); check5("t5 pre", 2, 2);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    check_eq("t5 rem", 32'(rem5), 32'd0);
    check_eq("t5 div", 32'(dv5), 32'd1);
    check_eq("t5 cnt", 32'(cnt5), 32'd0);
    check_eq("t5 ov", 32'(ov5), 32'd0);
    bubble(1'b0);
    check_eq("t5 ov after", 32'(ov5), 32'd0);

    // Long numbers: power-of-two divisors, counter saturation
    run_lsb40(40'hA5_3C96_F01B);
    run_lsb40(40'h13_579B_DF02);
    run_msb40(40'hC3_9E27_5A14);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
